// File: rtl/rv_isa_pkg.sv
// RV32I encoding constants shared by the instruction packer and the encoder.
package rv_isa_pkg;

    // Base opcodes of the RV32I integer instruction groups
    localparam logic [6:0] OP_LUI   = 7'h37;
    localparam logic [6:0] OP_AUIPC = 7'h17;
    localparam logic [6:0] OP_JAL   = 7'h6F;
    localparam logic [6:0] OP_JALR  = 7'h67;
    localparam logic [6:0] OP_BXX   = 7'h63;
    localparam logic [6:0] OP_LXX   = 7'h03;
    localparam logic [6:0] OP_SXX   = 7'h23;
    localparam logic [6:0] OP_IXX   = 7'h13;
    localparam logic [6:0] OP_RXX   = 7'h33;

    // Instruction formats; code 7 is reserved and always rejected
    typedef enum logic [2:0] {
        FMT_R      = 3'd0,
        FMT_I      = 3'd1,
        FMT_ISHIFT = 3'd2,
        FMT_S      = 3'd3,
        FMT_B      = 3'd4,
        FMT_U      = 3'd5,
        FMT_J      = 3'd6,
        FMT_BAD    = 3'd7
    } fmt_e;

    // Signed immediate limits (byte offsets) for each format
    localparam int IMM12_MIN = -2048;
    localparam int IMM12_MAX = 2047;
    localparam int SHAMT_MIN = 0;
    localparam int SHAMT_MAX = 31;
    localparam int IMM13_MIN = -4096;
    localparam int IMM13_MAX = 4094;
    localparam int IMM21_MIN = -(1 << 20);
    localparam int IMM21_MAX = (1 << 20) - 2;

    // Treat imm as a two's-complement value and test lo <= imm <= hi
    function automatic logic imm_in_range(input logic [31:0] imm, input int lo, input int hi);
        return ($signed(imm) >= lo) && ($signed(imm) <= hi);
    endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational RV32I word packer: decoded fields + immediate -> 32-bit word and legality.
import rv_isa_pkg::*;

module instr_pack (
    input  logic [2:0]  fmt,
    input  logic [6:0]  opcode,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [31:0] imm,
    output logic [31:0] instr,
    output logic        legal
);

    // Scatter the immediate into the format's bit positions and range-check it
    always_comb begin
        instr = '0;
        legal = 1'b0;
        case (fmt)
            FMT_R: begin
                instr = {funct7, rs2, rs1, funct3, rd, opcode};
                legal = 1'b1;
            end
            FMT_I: begin
                instr = {imm[11:0], rs1, funct3, rd, opcode};
                legal = imm_in_range(imm, IMM12_MIN, IMM12_MAX);
            end
            FMT_ISHIFT: begin
                instr = {funct7, imm[4:0], rs1, funct3, rd, opcode};
                legal = imm_in_range(imm, SHAMT_MIN, SHAMT_MAX);
            end
            FMT_S: begin
                instr = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
                legal = imm_in_range(imm, IMM12_MIN, IMM12_MAX);
            end
            FMT_B: begin
                instr = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
                legal = imm_in_range(imm, IMM13_MIN, IMM13_MAX) && !imm[0];
            end
            FMT_U: begin
                instr = {imm[31:12], rd, opcode};
                legal = (imm[11:0] == 12'd0);
            end
            FMT_J: begin
                instr = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
                legal = imm_in_range(imm, IMM21_MIN, IMM21_MAX) && !imm[0];
            end
            default: begin
                instr = '0;
                legal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Streaming RV32I encoder: valid/ready request in, addressed instruction-word stream out.
import rv_isa_pkg::*;

module instr_encoder #(
    parameter int AW        = 10,
    parameter int BASE_ADDR = 0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [2:0]    req_fmt,
    input  logic [6:0]    req_opcode,
    input  logic [4:0]    req_rd,
    input  logic [4:0]    req_rs1,
    input  logic [4:0]    req_rs2,
    input  logic [2:0]    req_funct3,
    input  logic [6:0]    req_funct7,
    input  logic [31:0]   req_imm,
    input  logic          req_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] out_addr,
    output logic [31:0]   out_instr,
    output logic          done,
    output logic          err,
    output logic [AW-1:0] err_addr
);

    logic [AW-1:0] cnt_reg;
    logic [31:0]   pack_instr;
    logic          pack_legal;
    logic          accept;
    logic          emit;
    logic          reject;

    instr_pack u_pack (
        .fmt    (req_fmt),
        .opcode (req_opcode),
        .rd     (req_rd),
        .rs1    (req_rs1),
        .rs2    (req_rs2),
        .funct3 (req_funct3),
        .funct7 (req_funct7),
        .imm    (req_imm),
        .instr  (pack_instr),
        .legal  (pack_legal)
    );

    // The single output slot is free when empty or being drained this cycle
    assign req_ready = !done && (!out_valid || out_ready);
    assign accept    = req_valid && req_ready;
    assign emit      = accept && pack_legal;
    assign reject    = accept && !pack_legal;

    // Output register: load on a legal accept, otherwise clear valid once consumed
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_instr <= '0;
            out_addr  <= '0;
        end else if (emit) begin
            out_valid <= 1'b1;
            out_instr <= pack_instr;
            out_addr  <= cnt_reg;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Word-address counter advances only for emitted words, wrapping naturally
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_reg <= AW'(BASE_ADDR);
        end else if (emit) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    // Sticky error flag; the address is latched only for the first rejection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err      <= 1'b0;
            err_addr <= '0;
        end else if (reject) begin
            err <= 1'b1;
            if (!err) begin
                err_addr <= cnt_reg;
            end
        end
    end

    // Sticky done flag once the final request has been consumed
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done <= 1'b0;
        end else if (accept && req_last) begin
            done <= 1'b1;
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed vectors, hand sequences and random stream.
module tb_instr_encoder;

    localparam int AW        = 4;
    localparam int BASE_ADDR = 0;
    localparam int NWORDS    = 1 << AW;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic [2:0]    req_fmt;
    logic [6:0]    req_opcode;
    logic [4:0]    req_rd;
    logic [4:0]    req_rs1;
    logic [4:0]    req_rs2;
    logic [2:0]    req_funct3;
    logic [6:0]    req_funct7;
    logic [31:0]   req_imm;
    logic          req_last;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_addr;
    logic [31:0]   out_instr;
    logic          done;
    logic          err;
    logic [AW-1:0] err_addr;

    always #5 clk = ~clk;

    instr_encoder #(.AW(AW), .BASE_ADDR(BASE_ADDR)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_fmt    (req_fmt),
        .req_opcode (req_opcode),
        .req_rd     (req_rd),
        .req_rs1    (req_rs1),
        .req_rs2    (req_rs2),
        .req_funct3 (req_funct3),
        .req_funct7 (req_funct7),
        .req_imm    (req_imm),
        .req_last   (req_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_addr   (out_addr),
        .out_instr  (out_instr),
        .done       (done),
        .err        (err),
        .err_addr   (err_addr)
    );

    typedef struct {
        logic [2:0]  fmt;
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic        last;
    } req_t;

    typedef struct {
        req_t        r;
        logic [31:0] exp_instr;
        bit          exp_legal;
    } vec_t;

    typedef struct {
        logic [31:0] instr;
        int          addr;
    } word_t;

    int    n_assert = 0;
    int    n_fail   = 0;

    // Reference state: words still owed downstream, plus counter and flags
    word_t q[$];
    int    m_cnt;
    bit    m_err;
    int    m_err_addr;
    bit    m_done;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic req_t mk(int fmt, int op, int rd, int rs1, int rs2, int f3, int f7,
                                int imm, bit last = 1'b0);
        req_t r;
        r.fmt  = 3'(fmt);
        r.op   = 7'(op);
        r.rd   = 5'(rd);
        r.rs1  = 5'(rs1);
        r.rs2  = 5'(rs2);
        r.f3   = 3'(f3);
        r.f7   = 7'(f7);
        r.imm  = 32'(imm);
        r.last = last;
        return r;
    endfunction

    // Encoding straight from the RV32I field layout; legality from integer ranges
    function automatic void ref_encode(input req_t r, output logic [31:0] w, output bit lg);
        longint v;
        v  = longint'($signed(r.imm));
        w  = 32'd0;
        lg = 1'b0;
        case (r.fmt)
            3'd0: begin w = {r.f7, r.rs2, r.rs1, r.f3, r.rd, r.op}; lg = 1'b1; end
            3'd1: begin w = {r.imm[11:0], r.rs1, r.f3, r.rd, r.op}; lg = (v >= -2048 && v <= 2047); end
            3'd2: begin w = {r.f7, r.imm[4:0], r.rs1, r.f3, r.rd, r.op}; lg = (v >= 0 && v <= 31); end
            3'd3: begin w = {r.imm[11:5], r.rs2, r.rs1, r.f3, r.imm[4:0], r.op}; lg = (v >= -2048 && v <= 2047); end
            3'd4: begin
                w  = {r.imm[12], r.imm[10:5], r.rs2, r.rs1, r.f3, r.imm[4:1], r.imm[11], r.op};
                lg = (v >= -4096 && v <= 4094 && (v % 2) == 0);
            end
            3'd5: begin w = {r.imm[31:12], r.rd, r.op}; lg = ((v % 4096) == 0); end
            3'd6: begin
                w  = {r.imm[20], r.imm[10:1], r.imm[11], r.imm[19:12], r.rd, r.op};
                lg = (v >= -(64'sd1 << 20) && v <= (64'sd1 << 20) - 2 && (v % 2) == 0);
            end
            default: begin w = 32'd0; lg = 1'b0; end
        endcase
    endfunction

    task automatic drive(input req_t r);
        req_valid  = 1'b1;
        req_fmt    = r.fmt;
        req_opcode = r.op;
        req_rd     = r.rd;
        req_rs1    = r.rs1;
        req_rs2    = r.rs2;
        req_funct3 = r.f3;
        req_funct7 = r.f7;
        req_imm    = r.imm;
        req_last   = r.last;
    endtask

    task automatic idle();
        req_valid = 1'b0;
        req_last  = 1'b0;
    endtask

    task automatic model_reset();
        q.delete();
        m_cnt      = BASE_ADDR % NWORDS;
        m_err      = 1'b0;
        m_err_addr = 0;
        m_done     = 1'b0;
    endtask

    // One clock: check outputs at the falling edge, advance the model at the rising edge
    task automatic run_cycle();
        bit          exp_ready;
        bit          acc;
        bit          cons;
        req_t        r;
        logic [31:0] w;
        bit          lg;
        @(negedge clk);
        chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
        if (q.size() != 0 && out_valid) begin
            chk("out_instr", out_instr, q[0].instr);
            chk("out_addr", 32'(out_addr), 32'(q[0].addr));
        end
        exp_ready = !m_done && (q.size() == 0 || out_ready);
        chk("req_ready", 32'(req_ready), 32'(exp_ready));
        chk("done", 32'(done), 32'(m_done));
        chk("err", 32'(err), 32'(m_err));
        chk("err_addr", 32'(err_addr), 32'(m_err_addr));
        acc  = req_valid && exp_ready;
        cons = (q.size() != 0) && out_ready;
        r = mk(req_fmt, req_opcode, req_rd, req_rs1, req_rs2, req_funct3, req_funct7, req_imm, req_last);
        @(posedge clk);
        if (cons) begin
            $display("word addr=%0d instr=%08h", q[0].addr, q[0].instr);
            void'(q.pop_front());
        end
        if (acc) begin
            ref_encode(r, w, lg);
            if (lg) begin
                q.push_back('{instr: w, addr: m_cnt});
                m_cnt = (m_cnt + 1) % NWORDS;
            end else begin
                $display("reject fmt=%0d imm=%08h at addr=%0d", r.fmt, r.imm, m_cnt);
                if (!m_err) m_err_addr = m_cnt;
                m_err = 1'b1;
            end
            if (r.last) m_done = 1'b1;
        end
        #1;
    endtask

    // Asynchronous reset applied between edges; outputs must clear without a clock
    task automatic do_reset();
        idle();
        out_ready = 1'b1;
        reset = 1'b1;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_instr", out_instr, 32'd0);
        chk("rst_out_addr", 32'(out_addr), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_err_addr", 32'(err_addr), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] gen_imm(int f, bit bad);
        case (f)
            1, 3:    return bad ? 32'(2048 + int'($urandom_range(0, 100)))
                                : 32'(int'($urandom_range(0, 4095)) - 2048);
            2:       return bad ? 32'(32 + int'($urandom_range(0, 200)))
                                : 32'($urandom_range(0, 31));
            4:       return bad ? 32'(int'($urandom_range(0, 2047)) * 2 - 4095)
                                : 32'(int'($urandom_range(0, 4094)) * 2 - 4096);
            5:       return bad ? ($urandom | 32'h1) : ($urandom & 32'hFFFF_F000);
            6:       return bad ? 32'h0010_0000
                                : 32'(int'($urandom_range(0, 1048575)) * 2 - 1048576);
            default: return $urandom;
        endcase
    endfunction

    vec_t        tbl[$];
    logic [31:0] held;
    int          prev_addr;

    initial begin
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_fmt    = '0;
        req_opcode = '0;
        req_rd     = '0;
        req_rs1    = '0;
        req_rs2    = '0;
        req_funct3 = '0;
        req_funct7 = '0;
        req_imm    = '0;
        req_last   = 1'b0;
        out_ready  = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        // First-error capture: three words, bad I at addr 3, good word still at 3
        for (int i = 0; i < 3; i++) begin
            drive(mk(1, 'h13, i + 1, 0, 0, 0, 0, i));
            run_cycle();
        end
        drive(mk(1, 'h13, 1, 0, 0, 0, 0, 4096));
        run_cycle();
        chk("err_first", 32'(err), 32'd1);
        chk("err_addr_first", 32'(err_addr), 32'd3);
        drive(mk(1, 'h13, 1, 0, 0, 0, 0, 5));
        run_cycle();
        chk("after_err_addr", 32'(out_addr), 32'd3);
        chk("after_err_instr", out_instr, 32'h0050_0093);
        for (int i = 0; i < 3; i++) begin
            drive(mk(0, 'h33, 3, 1, 2, 0, 0, 0));
            run_cycle();
        end
        drive(mk(3, 'h23, 0, 1, 2, 2, 0, -3000));
        run_cycle();
        chk("err_addr_kept", 32'(err_addr), 32'd3);
        idle();
        run_cycle();

        // Directed encodings with hand-computed words
        do_reset();
        tbl.push_back('{mk(1, 'h13, 1, 0, 0, 0, 0, 5),              32'h0050_0093, 1'b1});
        tbl.push_back('{mk(5, 'h37, 2, 0, 0, 0, 0, 'h1234_5000),    32'h1234_5137, 1'b1});
        tbl.push_back('{mk(5, 'h37, 2, 0, 0, 0, 0, 'h1234_5001),    32'h0,         1'b0});
        tbl.push_back('{mk(4, 'h63, 0, 1, 2, 0, 0, -4),             32'hFE20_8EE3, 1'b1});
        tbl.push_back('{mk(6, 'h6F, 1, 0, 0, 0, 0, 8),              32'h0080_00EF, 1'b1});
        tbl.push_back('{mk(0, 'h33, 3, 1, 2, 0, 'h20, 'h7777),      32'h4020_81B3, 1'b1});
        tbl.push_back('{mk(2, 'h13, 5, 6, 0, 5, 'h20, 3),           32'h4033_5293, 1'b1});
        tbl.push_back('{mk(2, 'h13, 5, 6, 0, 5, 'h20, 32),          32'h0,         1'b0});
        tbl.push_back('{mk(2, 'h13, 5, 6, 0, 5, 'h20, -1),          32'h0,         1'b0});
        tbl.push_back('{mk(1, 'h13, 1, 0, 0, 0, 0, -2048),          32'h8000_0093, 1'b1});
        tbl.push_back('{mk(1, 'h13, 1, 0, 0, 0, 0, 2047),           32'h7FF0_0093, 1'b1});
        tbl.push_back('{mk(1, 'h13, 1, 0, 0, 0, 0, 2048),           32'h0,         1'b0});
        tbl.push_back('{mk(3, 'h23, 0, 1, 2, 2, 0, -4),             32'hFE20_AE23, 1'b1});
        tbl.push_back('{mk(4, 'h63, 0, 0, 0, 0, 0, 4094),           32'h7E00_0FE3, 1'b1});
        tbl.push_back('{mk(4, 'h63, 0, 0, 0, 0, 0, -4096),          32'h8000_0063, 1'b1});
        tbl.push_back('{mk(4, 'h63, 0, 0, 0, 0, 0, 4096),           32'h0,         1'b0});
        tbl.push_back('{mk(4, 'h63, 0, 0, 0, 0, 0, 6 - 3),          32'h0,         1'b0});
        tbl.push_back('{mk(6, 'h6F, 0, 0, 0, 0, 0, -1048576),       32'h8000_006F, 1'b1});
        tbl.push_back('{mk(6, 'h6F, 0, 0, 0, 0, 0, 1048574),        32'h7FFF_F06F, 1'b1});
        tbl.push_back('{mk(6, 'h6F, 0, 0, 0, 0, 0, 1048576),        32'h0,         1'b0});
        tbl.push_back('{mk(6, 'h6F, 0, 0, 0, 0, 0, 7),              32'h0,         1'b0});
        tbl.push_back('{mk(7, 'h13, 1, 0, 0, 0, 0, 0),              32'h0,         1'b0});
        foreach (tbl[i]) begin
            drive(tbl[i].r);
            out_ready = 1'b1;
            run_cycle();
            idle();
            chk($sformatf("tbl%0d_valid", i), 32'(out_valid), 32'(tbl[i].exp_legal));
            if (tbl[i].exp_legal) chk($sformatf("tbl%0d_instr", i), out_instr, tbl[i].exp_instr);
        end
        run_cycle();

        // Backpressure: word held while out_ready=0, then full-rate drain
        out_ready = 1'b0;
        drive(mk(1, 'h13, 7, 1, 0, 0, 0, 100));
        run_cycle();
        held = out_instr;
        for (int i = 0; i < 3; i++) begin
            drive(mk(1, 'h13, 8 + i, 1, 0, 0, 0, 200 + i));
            run_cycle();
            chk("bp_req_ready", 32'(req_ready), 32'd0);
            chk("bp_hold", out_instr, held);
        end
        out_ready = 1'b1;
        prev_addr = int'(out_addr);
        for (int i = 0; i < 4; i++) begin
            drive(mk(1, 'h13, 12 + i, 2, 0, 0, 0, 300 + i));
            run_cycle();
            chk("bb_valid", 32'(out_valid), 32'd1);
            chk("bb_addr", 32'(out_addr), 32'((prev_addr + 1) % NWORDS));
            prev_addr = int'(out_addr);
        end
        idle();
        run_cycle();

        // Random stream against the reference model
        for (int n = 0; n < 400; n++) begin
            int f;
            bit bad;
            f   = ($urandom_range(0, 19) == 0) ? 7 : int'($urandom_range(0, 6));
            bad = ($urandom_range(0, 6) == 0);
            drive(mk(f, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
                     int'(gen_imm(f, bad))));
            req_valid = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            run_cycle();
        end
        out_ready = 1'b1;
        for (int n = 0; n < 20 && !m_done; n++) begin
            drive(mk(1, 'h13, 9, 9, 0, 0, 0, 9, 1'b1));
            run_cycle();
        end
        chk("last_accepted", 32'(m_done), 32'd1);
        drive(mk(1, 'h13, 9, 9, 0, 0, 0, 9));
        for (int n = 0; n < 3; n++) run_cycle();
        chk("done_blocks", 32'(req_ready), 32'd0);

        // Done sequence from reset, then asynchronous reset with a word pending
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(mk(1, 'h13, i + 1, 0, 0, 0, 0, i, i == 4));
            run_cycle();
            chk("seq_addr", 32'(out_addr), 32'(i % NWORDS));
        end
        chk("seq_done", 32'(done), 32'd1);
        chk("seq_ready", 32'(req_ready), 32'd0);
        out_ready = 1'b0;
        drive(mk(1, 'h13, 1, 0, 0, 0, 0, 1));
        run_cycle();
        chk("pending_valid", 32'(out_valid), 32'd1);
        do_reset();
        drive(mk(1, 'h13, 1, 0, 0, 0, 0, 5));
        run_cycle();
        chk("post_rst_addr", 32'(out_addr), 32'(BASE_ADDR % NWORDS));
        idle();
        run_cycle();
        run_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
